// File: rtl/fetch_stage.sv
// IF stage: owns PC, reads imem combinationally, registers the word into IF/ID (1-cycle fetch latency).
// Backpressure: IF/ID holds while id_valid && !id_ready; redirect flushes IF/ID and beats any stall or halt.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc_plus4,
  input  logic             redirect,
  input  logic [31:0]      redirect_target,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic {FETCH, HALT} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } ifid_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             id_valid_q, id_valid_d;
  ifid_t            ifid_q, ifid_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc_plus4;
  logic        load;
  logic        halt_word;

  assign pc_plus4  = pc_q + 32'd4;
  // JMP -1: jump opcode with an all-ones offset, i.e. branches to itself
  assign halt_word = (imem_data[31:26] == 6'b101010) && (imem_data[15:0] == 16'hFFFF);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    ifid_d        = ifid_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;
    load          = (state_q == FETCH) && !redirect && (!id_valid_q || id_ready);

    if (redirect) begin
      pc_d       = redirect_target & ~32'h3;
      id_valid_d = 1'b0;
      state_d    = FETCH;
      halted_d   = 1'b0;
    end else if (load) begin
      ifid_d.instr    = imem_data;
      ifid_d.pc_plus4 = pc_plus4;
      id_valid_d      = 1'b1;
      if (fetch_count_q != {CNT_W{1'b1}}) begin
        fetch_count_d = fetch_count_q + CNT_W'(1);
      end
      // PC parks on the halt word so a later redirect is the only way out
      if (halt_word) begin
        state_d  = HALT;
        halted_d = 1'b1;
      end else begin
        pc_d = pc_plus4;
      end
    end else if (id_valid_q && id_ready) begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      ifid_q        <= '0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      ifid_q        <= ifid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_valid    = id_valid_q;
  assign id_instr    = ifid_q.instr;
  assign id_pc_plus4 = ifid_q.pc_plus4;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the multicycle MIPS core. Owns the program counter, drives the word address into the combinational instruction memory, and captures the returned word into an IF/ID holding register. That register is offered to decode over a valid/ready handshake. The stage also accepts branch/jump redirects from downstream and parks itself on the self-loop halt instruction (JMP -1).

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC at reset; bits [1:0] must be 0.
- CNT_W, 16, width of the fetch counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- imem_addr  out  32  byte address to instruction memory, always equal to pc.
- imem_data  in  32  instruction word, valid combinationally in the same cycle.
- id_valid  out  1  IF/ID register holds an instruction for decode.
- id_ready  in  1  decode accepts id_instr this cycle.
- id_instr  out  32  latched instruction.
- id_pc_plus4  out  32  address of the latched instruction + 4.
- redirect  in  1  one-cycle pulse; load PC from redirect_target and flush IF/ID.
- redirect_target  in  32  new byte address; bits [1:0] are ignored and forced to 00.
- halted  out  1  stage is in HALT.
- fetch_count  out  CNT_W  number of instructions loaded into IF/ID, saturating.

## Operation
- States are FETCH and HALT. Reset enters FETCH.
- Load condition: `load = (state==FETCH) && !redirect && (!id_valid || id_ready)`.
- On load:
  - id_instr <= imem_data
  - id_pc_plus4 <= pc+4
  - id_valid <= 1
  - pc <= pc+4
  - fetch_count increments
- In FETCH with no load and no redirect:
  - if id_valid && id_ready, id_valid <= 0. Unreachable in FETCH, because load is true there.
  - otherwise all registers hold. This is a stall; id_instr stays stable while id_valid=1 && !id_ready.
- Halt detect: a loaded word with imem_data[31:26]=6'b101010 and imem_data[15:0]=16'hFFFF also sets state <= HALT and halted <= 1.
  - The halt word itself is presented to decode normally.
  - PC does not advance past it: pc stays at the halt word's address.
- In HALT:
  - no loads; pc frozen.
  - id_valid clears once the halt word is accepted (id_ready=1).
  - fetch_count frozen.
- Redirect has the highest priority in any state:
  - pc <= {redirect_target[31:2],2'b00}
  - id_valid <= 0 (flush; id_instr and id_pc_plus4 may hold stale values)
  - state <= FETCH; halted <= 0
  - no load that cycle
- Arithmetic and saturation:
  - pc+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - fetch_count saturates at all-ones and never wraps.
- Reset values, applied asynchronously:
  - pc = RESET_PC
  - id_valid = 0
  - id_instr = 32'h0 (NOP)
  - id_pc_plus4 = 0
  - halted = 0
  - fetch_count = 0
  - state = FETCH
- Reset asserted mid-stall or mid-halt discards all contents immediately; no partial update survives.

## Timing
- imem_addr is a pure register output, so there are no combinational paths from inputs to imem_addr.
- id_* and halted are registered outputs.
- The only combinational input-to-state path is imem_data/id_ready/redirect into the next-state logic.
- Fetch latency: the word at address A appears on id_instr one edge after pc=A with load true.
- Sustained throughput is 1 instruction/cycle while id_ready=1.
- After reset deassertion:
  - first edge: id_valid=1, id_instr=mem[RESET_PC], pc=RESET_PC+4.
- Redirect pulse at edge N:
  - edge N: id_valid=0, pc=target.
  - edge N+1: id_instr=mem[target], id_valid=1.
  - The bubble is exactly one cycle.
- Redirect and id_ready high in the same cycle: the held instruction counts as accepted by decode. It is flushed regardless and is not re-presented.
- Halt: halted rises on the same edge that loads the halt word.
- Redirect during HALT: halted=0 after that edge; fetch resumes from target on the next edge.

## Test plan
- Reset/streaming:
  - Stimulus: RESET_PC=0, id_ready=1, memory holds NOP and Addi r1,r0,1546 (32'h8001060A).
  - Required: edge 1 gives id_instr=0, id_pc_plus4=4; edge 2 gives id_instr=32'h8001060A, id_pc_plus4=8; fetch_count=2.
- Stall:
  - Stimulus: hold id_ready=0 for 3 cycles with id_valid=1.
  - Required: id_instr, pc and fetch_count unchanged across the stall; streaming resumes the cycle after id_ready=1.
- Redirect:
  - Stimulus: pulse redirect with target 32'h0000_0143 while pc=32'h50.
  - Required: pc=32'h140 and id_valid=0 after that edge; next edge gives id_pc_plus4=32'h144.
- Redirect collision:
  - Stimulus: redirect together with id_ready=0 and id_valid=1.
  - Required: the stalled instruction is dropped, id_valid=0, and it is not re-presented.
- Halt:
  - Stimulus: word 32'hA800FFFF (JMP -1) at address 32'h190.
  - Required: halted=1 and pc=32'h190 frozen; id_valid drops after one accept; a redirect to 0 clears halted and fetch restarts at 0.
- Wrap and saturation:
  - Stimulus: redirect to 32'hFFFF_FFFC; separately, preload the counter to near all-ones using CNT_W=4.
  - Required: the next pc is 0; fetch_count sticks at 4'hF.
